axi_burst_to_lite: RTL and testbench

AXI_BURST_TO_LITE -- requirements
Module: axi_burst_to_lite

---
 rtl/axi_burst_to_lite.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi_burst_to_lite.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_to_lite.sv
// AXI4 burst to AXI-lite splitter: every host burst becomes len+1 single-beat
// lite transactions. Read and write paths are independent, one burst each.
// Ports: clk_i/rst_ni; host_* AXI4 device port; lite_* AXI-lite host port.
module axi_burst_to_lite #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IdWidth-1:0]     host_aw_id_i,
    input  logic [AddrWidth-1:0]   host_aw_addr_i,
    input  logic [7:0]             host_aw_len_i,
    input  logic [2:0]             host_aw_size_i,
    input  logic [1:0]             host_aw_burst_i,
    input  logic                   host_aw_valid_i,
    output logic                   host_aw_ready_o,
    input  logic [DataWidth-1:0]   host_w_data_i,
    input  logic [DataWidth/8-1:0] host_w_strb_i,
    input  logic                   host_w_last_i,
    input  logic                   host_w_valid_i,
    output logic                   host_w_ready_o,
    output logic [IdWidth-1:0]     host_b_id_o,
    output logic [1:0]             host_b_resp_o,
    output logic                   host_b_valid_o,
    input  logic                   host_b_ready_i,
    input  logic [IdWidth-1:0]     host_ar_id_i,
    input  logic [AddrWidth-1:0]   host_ar_addr_i,
    input  logic [7:0]             host_ar_len_i,
    input  logic [2:0]             host_ar_size_i,
    input  logic [1:0]             host_ar_burst_i,
    input  logic                   host_ar_valid_i,
    output logic                   host_ar_ready_o,
    output logic [IdWidth-1:0]     host_r_id_o,
    output logic [DataWidth-1:0]   host_r_data_o,
    output logic [1:0]             host_r_resp_o,
    output logic                   host_r_last_o,
    output logic                   host_r_valid_o,
    input  logic                   host_r_ready_i,
    output logic [AddrWidth-1:0]   lite_aw_addr_o,
    output logic                   lite_aw_valid_o,
    input  logic                   lite_aw_ready_i,
    output logic [DataWidth-1:0]   lite_w_data_o,
    output logic [DataWidth/8-1:0] lite_w_strb_o,
    output logic                   lite_w_valid_o,
    input  logic                   lite_w_ready_i,
    input  logic [1:0]             lite_b_resp_i,
    input  logic                   lite_b_valid_i,
    output logic                   lite_b_ready_o,
    output logic [AddrWidth-1:0]   lite_ar_addr_o,
    output logic                   lite_ar_valid_o,
    input  logic                   lite_ar_ready_i,
    input  logic [DataWidth-1:0]   lite_r_data_i,
    input  logic [1:0]             lite_r_resp_i,
    input  logic                   lite_r_valid_i,
    output logic                   lite_r_ready_o
);

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_BURST} r_state_e;

    // Beat count, not WLAST, ends a write burst.
    logic unused_w_last;
    assign unused_w_last = host_w_last_i;

    // Address of the beat after cur; reserved burst type falls into INCR.
    function automatic logic [AddrWidth-1:0] next_addr(
        input logic [AddrWidth-1:0] cur,
        input logic [2:0]           size,
        input logic [7:0]           len,
        input logic [1:0]           burst
    );
        logic [AddrWidth-1:0] inc, aligned, incr, mask, nxt;
        inc     = AddrWidth'(1) << size;
        aligned = cur & ~(inc - AddrWidth'(1));
        incr    = aligned + inc;
        mask    = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
        unique case (burst)
            2'b00:   nxt = cur;
            2'b10:   nxt = (aligned & ~mask) | (incr & mask);
            default: nxt = incr;
        endcase
        return nxt;
    endfunction

    // ---------------- write path ----------------
    w_state_e             w_state_q, w_state_d;
    logic [IdWidth-1:0]   w_id_q, w_id_d;
    logic [7:0]           w_len_q, w_len_d;
    logic [2:0]           w_size_q, w_size_d;
    logic [1:0]           w_burst_q, w_burst_d;
    logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
    logic                 aw_vld_q, aw_vld_d;
    logic [8:0]           aw_cnt_q, aw_cnt_d;
    logic [8:0]           w_cnt_q, w_cnt_d;
    logic [8:0]           b_cnt_q, b_cnt_d;
    logic [1:0]           resp_q, resp_d;
    logic [8:0]           w_total;
    logic                 w_rem;

    assign w_total         = {1'b0, w_len_q} + 9'd1;
    assign w_rem           = w_cnt_q < w_total;
    assign lite_aw_addr_o  = aw_addr_q;
    assign lite_aw_valid_o = aw_vld_q;
    assign lite_w_data_o   = host_w_data_i;
    assign lite_w_strb_o   = host_w_strb_i;
    assign host_b_id_o     = w_id_q;
    assign host_b_resp_o   = resp_q;

    always_comb begin
        w_state_d       = w_state_q;
        w_id_d          = w_id_q;
        w_len_d         = w_len_q;
        w_size_d        = w_size_q;
        w_burst_d       = w_burst_q;
        aw_addr_d       = aw_addr_q;
        aw_vld_d        = aw_vld_q;
        aw_cnt_d        = aw_cnt_q;
        w_cnt_d         = w_cnt_q;
        b_cnt_d         = b_cnt_q;
        resp_d          = resp_q;
        host_aw_ready_o = 1'b0;
        host_w_ready_o  = 1'b0;
        lite_w_valid_o  = 1'b0;
        lite_b_ready_o  = 1'b0;
        host_b_valid_o  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                host_aw_ready_o = 1'b1;
                if (host_aw_valid_i) begin
                    w_state_d = W_BURST;
                    w_id_d    = host_aw_id_i;
                    w_len_d   = host_aw_len_i;
                    w_size_d  = host_aw_size_i;
                    w_burst_d = host_aw_burst_i;
                    aw_addr_d = host_aw_addr_i;
                    aw_vld_d  = 1'b1;
                    aw_cnt_d  = '0;
                    w_cnt_d   = '0;
                    b_cnt_d   = '0;
                    resp_d    = 2'b00;
                end
            end
            W_BURST: begin
                lite_w_valid_o = host_w_valid_i && w_rem;
                host_w_ready_o = lite_w_ready_i && w_rem;
                lite_b_ready_o = 1'b1;
                // AW stays up back-to-back until every beat address is out.
                if (aw_vld_q && lite_aw_ready_i) begin
                    aw_cnt_d  = aw_cnt_q + 9'd1;
                    aw_addr_d = next_addr(aw_addr_q, w_size_q,
                                          w_len_q, w_burst_q);
                    aw_vld_d  = aw_cnt_d < w_total;
                end
                if (host_w_valid_i && lite_w_ready_i && w_rem) begin
                    w_cnt_d = w_cnt_q + 9'd1;
                end
                if (lite_b_valid_i) begin
                    b_cnt_d = b_cnt_q + 9'd1;
                    if (lite_b_resp_i > resp_q) begin
                        resp_d = lite_b_resp_i;
                    end
                    if (b_cnt_d == w_total) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                lite_b_ready_o = 1'b1;
                host_b_valid_o = 1'b1;
                if (host_b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            aw_addr_q <= '0;
            aw_vld_q  <= 1'b0;
            aw_cnt_q  <= '0;
            w_cnt_q   <= '0;
            b_cnt_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            aw_addr_q <= aw_addr_d;
            aw_vld_q  <= aw_vld_d;
            aw_cnt_q  <= aw_cnt_d;
            w_cnt_q   <= w_cnt_d;
            b_cnt_q   <= b_cnt_d;
            resp_q    <= resp_d;
        end
    end

    // ---------------- read path ----------------
    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [7:0]           r_len_q, r_len_d;
    logic [2:0]           r_size_q, r_size_d;
    logic [1:0]           r_burst_q, r_burst_d;
    logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
    logic                 ar_vld_q, ar_vld_d;
    logic [8:0]           ar_cnt_q, ar_cnt_d;
    logic [8:0]           r_cnt_q, r_cnt_d;
    logic [8:0]           r_total;

    assign r_total         = {1'b0, r_len_q} + 9'd1;
    assign lite_ar_addr_o  = ar_addr_q;
    assign lite_ar_valid_o = ar_vld_q;
    assign host_r_id_o     = r_id_q;
    assign host_r_data_o   = lite_r_data_i;
    assign host_r_resp_o   = lite_r_resp_i;

    always_comb begin
        r_state_d       = r_state_q;
        r_id_d          = r_id_q;
        r_len_d         = r_len_q;
        r_size_d        = r_size_q;
        r_burst_d       = r_burst_q;
        ar_addr_d       = ar_addr_q;
        ar_vld_d        = ar_vld_q;
        ar_cnt_d        = ar_cnt_q;
        r_cnt_d         = r_cnt_q;
        host_ar_ready_o = 1'b0;
        host_r_valid_o  = 1'b0;
        host_r_last_o   = 1'b0;
        lite_r_ready_o  = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                host_ar_ready_o = 1'b1;
                if (host_ar_valid_i) begin
                    r_state_d = R_BURST;
                    r_id_d    = host_ar_id_i;
                    r_len_d   = host_ar_len_i;
                    r_size_d  = host_ar_size_i;
                    r_burst_d = host_ar_burst_i;
                    ar_addr_d = host_ar_addr_i;
                    ar_vld_d  = 1'b1;
                    ar_cnt_d  = '0;
                    r_cnt_d   = '0;
                end
            end
            R_BURST: begin
                host_r_valid_o = lite_r_valid_i;
                lite_r_ready_o = host_r_ready_i;
                host_r_last_o  = r_cnt_q == {1'b0, r_len_q};
                if (ar_vld_q && lite_ar_ready_i) begin
                    ar_cnt_d  = ar_cnt_q + 9'd1;
                    ar_addr_d = next_addr(ar_addr_q, r_size_q,
                                          r_len_q, r_burst_q);
                    ar_vld_d  = ar_cnt_d < r_total;
                end
                if (lite_r_valid_i && host_r_ready_i) begin
                    r_cnt_d = r_cnt_q + 9'd1;
                    if (r_cnt_d == r_total) begin
                        r_state_d = R_IDLE;
                        ar_vld_d  = 1'b0;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            ar_addr_q <= '0;
            ar_vld_q  <= 1'b0;
            ar_cnt_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            ar_addr_q <= ar_addr_d;
            ar_vld_q  <= ar_vld_d;
            ar_cnt_q  <= ar_cnt_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_to_lite.sv
// Directed bench for axi_burst_to_lite with lite slave models.
// Checks beat addresses, data, merged resp, R last/id and reset abandon.
module tb_axi_burst_to_lite;

    localparam int LIM = 3000;
    localparam int N = 300;
    localparam logic [63:0] RKEY = 64'hDEAD_BEEF_0000_0000;
    localparam logic [63:0] WKEY = 64'hC0DE_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [3:0]  host_aw_id;
    logic [63:0] host_aw_addr;
    logic [7:0]  host_aw_len;
    logic [2:0]  host_aw_size;
    logic [1:0]  host_aw_burst;
    logic        host_aw_valid, host_aw_ready_o;
    logic [63:0] host_w_data;
    logic [7:0]  host_w_strb;
    logic        host_w_last, host_w_valid, host_w_ready_o;
    logic [3:0]  host_b_id_o;
    logic [1:0]  host_b_resp_o;
    logic        host_b_valid_o, host_b_ready;
    logic [3:0]  host_ar_id;
    logic [63:0] host_ar_addr;
    logic [7:0]  host_ar_len;
    logic [2:0]  host_ar_size;
    logic [1:0]  host_ar_burst;
    logic        host_ar_valid, host_ar_ready_o;
    logic [3:0]  host_r_id_o;
    logic [63:0] host_r_data_o;
    logic [1:0]  host_r_resp_o;
    logic        host_r_last_o, host_r_valid_o, host_r_ready;
    logic [63:0] lite_aw_addr_o;
    logic        lite_aw_valid_o, lite_aw_ready;
    logic [63:0] lite_w_data_o;
    logic [7:0]  lite_w_strb_o;
    logic        lite_w_valid_o, lite_w_ready;
    logic [1:0]  lite_b_resp;
    logic        lite_b_valid, lite_b_ready_o;
    logic [63:0] lite_ar_addr_o;
    logic        lite_ar_valid_o, lite_ar_ready;
    logic [63:0] lite_r_data;
    logic [1:0]  lite_r_resp;
    logic        lite_r_valid, lite_r_ready_o;

    axi_burst_to_lite dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_aw_id_i(host_aw_id), .host_aw_addr_i(host_aw_addr),
        .host_aw_len_i(host_aw_len), .host_aw_size_i(host_aw_size),
        .host_aw_burst_i(host_aw_burst), .host_aw_valid_i(host_aw_valid),
        .host_aw_ready_o(host_aw_ready_o),
        .host_w_data_i(host_w_data), .host_w_strb_i(host_w_strb),
        .host_w_last_i(host_w_last), .host_w_valid_i(host_w_valid),
        .host_w_ready_o(host_w_ready_o),
        .host_b_id_o(host_b_id_o), .host_b_resp_o(host_b_resp_o),
        .host_b_valid_o(host_b_valid_o), .host_b_ready_i(host_b_ready),
        .host_ar_id_i(host_ar_id), .host_ar_addr_i(host_ar_addr),
        .host_ar_len_i(host_ar_len), .host_ar_size_i(host_ar_size),
        .host_ar_burst_i(host_ar_burst), .host_ar_valid_i(host_ar_valid),
        .host_ar_ready_o(host_ar_ready_o),
        .host_r_id_o(host_r_id_o), .host_r_data_o(host_r_data_o),
        .host_r_resp_o(host_r_resp_o), .host_r_last_o(host_r_last_o),
        .host_r_valid_o(host_r_valid_o), .host_r_ready_i(host_r_ready),
        .lite_aw_addr_o(lite_aw_addr_o), .lite_aw_valid_o(lite_aw_valid_o),
        .lite_aw_ready_i(lite_aw_ready),
        .lite_w_data_o(lite_w_data_o), .lite_w_strb_o(lite_w_strb_o),
        .lite_w_valid_o(lite_w_valid_o), .lite_w_ready_i(lite_w_ready),
        .lite_b_resp_i(lite_b_resp), .lite_b_valid_i(lite_b_valid),
        .lite_b_ready_o(lite_b_ready_o),
        .lite_ar_addr_o(lite_ar_addr_o), .lite_ar_valid_o(lite_ar_valid_o),
        .lite_ar_ready_i(lite_ar_ready),
        .lite_r_data_i(lite_r_data), .lite_r_resp_i(lite_r_resp),
        .lite_r_valid_i(lite_r_valid), .lite_r_ready_o(lite_r_ready_o)
    );

    int total = 0;
    int bad = 0;
    bit stall = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy();
        return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // lite slave state
    logic [63:0] aw_log [N];
    logic [63:0] w_log  [N];
    logic [63:0] ar_log [N];
    logic [1:0]  bresp_tab [N];
    int aw_n, w_n, b_n, ar_n, r_n;

    // host read capture
    logic [63:0] rd_data [N];
    logic        rd_last [N];
    logic [3:0]  rd_id   [N];
    int rd_n;

    task automatic clear_logs();
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        for (int i = 0; i < N; i++) bresp_tab[i] = 2'b00;
    endtask

    initial begin
        lite_aw_ready = 0; lite_w_ready = 0;
        lite_b_valid = 0; lite_b_resp = 0;
        forever begin
            @(negedge clk);
            lite_aw_ready = rdy();
            lite_w_ready = rdy();
            lite_b_valid = (b_n < aw_n) && (b_n < w_n);
            lite_b_resp = lite_b_valid ? bresp_tab[b_n % N] : 2'b00;
            #4;
            if (lite_aw_valid_o && lite_aw_ready) begin
                if (aw_n < N) aw_log[aw_n] = lite_aw_addr_o;
                aw_n++;
            end
            if (lite_w_valid_o && lite_w_ready) begin
                if (w_n < N) w_log[w_n] = lite_w_data_o;
                w_n++;
            end
            if (lite_b_valid && lite_b_ready_o) b_n++;
        end
    end

    initial begin
        lite_ar_ready = 0; lite_r_valid = 0;
        lite_r_data = 0; lite_r_resp = 0;
        forever begin
            @(negedge clk);
            lite_ar_ready = rdy();
            lite_r_valid = r_n < ar_n;
            lite_r_data = lite_r_valid ? (ar_log[r_n % N] ^ RKEY) : '0;
            #4;
            if (lite_ar_valid_o && lite_ar_ready) begin
                if (ar_n < N) ar_log[ar_n] = lite_ar_addr_o;
                ar_n++;
            end
            if (lite_r_valid && lite_r_ready_o) r_n++;
        end
    end

    // all host tasks start and end on a negedge
    task automatic send_aw(input logic [3:0] id, input logic [63:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, output bit ok);
        int t; bit hs;
        host_aw_id = id; host_aw_addr = a; host_aw_len = len;
        host_aw_size = sz; host_aw_burst = bu; host_aw_valid = 1;
        ok = 0; t = 0;
        while (!ok && t < LIM) begin
            #4; hs = host_aw_ready_o;
            @(negedge clk);
            if (hs) ok = 1;
            t++;
        end
        host_aw_valid = 0;
    endtask

    task automatic send_w(input logic [63:0] d, input bit last,
                          output bit ok);
        int t; bit hs;
        host_w_data = d; host_w_strb = '1; host_w_last = last;
        ok = 0; t = 0;
        while (!ok && t < LIM) begin
            if (!host_w_valid) host_w_valid = rdy();
            #4; hs = host_w_valid && host_w_ready_o;
            @(negedge clk);
            if (hs) ok = 1;
            t++;
        end
        host_w_valid = 0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] a,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, output logic [3:0] bid,
                            output logic [1:0] bresp, output bit ok);
        bit k; int t;
        @(negedge clk);
        send_aw(id, a, len, sz, bu, ok);
        for (int b = 0; b <= int'(len); b++) begin
            send_w(WKEY + 64'(b), b == int'(len), k);
            ok = ok && k;
        end
        bid = 'x; bresp = 'x; k = 0; t = 0;
        while (!k && t < LIM) begin
            host_b_ready = rdy();
            #4;
            if (host_b_valid_o && host_b_ready) begin
                k = 1; bid = host_b_id_o; bresp = host_b_resp_o;
            end
            @(negedge clk);
            t++;
        end
        host_b_ready = 0;
        ok = ok && k;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, output bit ok);
        int t; bit hs;
        @(negedge clk);
        host_ar_id = id; host_ar_addr = a; host_ar_len = len;
        host_ar_size = sz; host_ar_burst = bu; host_ar_valid = 1;
        ok = 0; t = 0;
        while (!ok && t < LIM) begin
            #4; hs = host_ar_ready_o;
            @(negedge clk);
            if (hs) ok = 1;
            t++;
        end
        host_ar_valid = 0;
        rd_n = 0; t = 0;
        while (rd_n <= int'(len) && t < LIM) begin
            host_r_ready = rdy();
            #4;
            if (host_r_valid_o && host_r_ready) begin
                rd_data[rd_n] = host_r_data_o;
                rd_last[rd_n] = host_r_last_o;
                rd_id[rd_n] = host_r_id_o;
                rd_n++;
            end
            @(negedge clk);
            t++;
        end
        host_r_ready = 0;
        ok = ok && (rd_n == int'(len) + 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bid;
        logic [1:0] bresp;
        bit ok, ok2;
        int errs, nb;
        logic [63:0] exp4 [4];

        rst_ni = 0;
        host_aw_valid = 0; host_w_valid = 0; host_b_ready = 0;
        host_ar_valid = 0; host_r_ready = 0;
        host_aw_id = 0; host_aw_addr = 0; host_aw_len = 0;
        host_aw_size = 0; host_aw_burst = 0;
        host_w_data = 0; host_w_strb = 0; host_w_last = 0;
        host_ar_id = 0; host_ar_addr = 0; host_ar_len = 0;
        host_ar_size = 0; host_ar_burst = 0;
        clear_logs();
        repeat (3) @(negedge clk);
        rst_ni = 1;
        @(negedge clk);
        #4;
        check("rst_aw_ready", host_aw_ready_o, 1);
        check("rst_ar_ready", host_ar_ready_o, 1);
        check("rst_b_valid", host_b_valid_o, 0);
        check("rst_r_valid", host_r_valid_o, 0);
        check("rst_law_valid", lite_aw_valid_o, 0);
        check("rst_lw_valid", lite_w_valid_o, 0);
        check("rst_lar_valid", lite_ar_valid_o, 0);

        // INCR write id=3 0x100 len=3 size=3
        do_write(4'd3, 64'h100, 8'd3, 3'd3, 2'b01, bid, bresp, ok);
        check("incr_w_done", ok, 1);
        check("incr_w_aw_n", aw_n, 4);
        exp4 = '{64'h100, 64'h108, 64'h110, 64'h118};
        for (int i = 0; i < 4; i++) check($sformatf("incr_w_aw%0d", i),
                                          aw_log[i], exp4[i]);
        check("incr_w_w_n", w_n, 4);
        check("incr_w_d3", w_log[3], 64'hC0DE_0000_0000_0003);
        check("incr_w_bid", bid, 4'd3);
        check("incr_w_bresp", bresp, 2'b00);

        // WRAP read id=6 0x38 len=3 size=3
        clear_logs();
        do_read(4'd6, 64'h38, 8'd3, 3'd3, 2'b10, ok);
        check("wrap_r_done", ok, 1);
        exp4 = '{64'h38, 64'h20, 64'h28, 64'h30};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_r_ar%0d", i), ar_log[i], exp4[i]);
            check($sformatf("wrap_r_d%0d", i), rd_data[i], exp4[i] ^ RKEY);
            check($sformatf("wrap_r_last%0d", i), rd_last[i], i == 3);
            check($sformatf("wrap_r_id%0d", i), rd_id[i], 4'd6);
        end

        // FIXED write len=2 0x44, 2nd B SLVERR
        clear_logs();
        bresp_tab[1] = 2'b10;
        do_write(4'd9, 64'h44, 8'd2, 3'd2, 2'b00, bid, bresp, ok);
        check("fix_w_done", ok, 1);
        check("fix_w_aw_n", aw_n, 3);
        for (int i = 0; i < 3; i++) check($sformatf("fix_w_aw%0d", i),
                                          aw_log[i], 64'h44);
        check("fix_w_bid", bid, 4'd9);
        check("fix_w_bresp", bresp, 2'b10);

        // unaligned INCR read 0x103 size=2 len=1
        clear_logs();
        do_read(4'd1, 64'h103, 8'd1, 3'd2, 2'b01, ok);
        check("unal_r_done", ok, 1);
        check("unal_r_ar0", ar_log[0], 64'h103);
        check("unal_r_ar1", ar_log[1], 64'h104);
        check("unal_r_last0", rd_last[0], 0);
        check("unal_r_last1", rd_last[1], 1);

        // reserved burst acts as INCR
        clear_logs();
        do_read(4'd2, 64'h200, 8'd1, 3'd3, 2'b11, ok);
        check("rsv_r_ar1", ar_log[1], 64'h208);

        // concurrent write len=255 and read len=0 with stalls
        clear_logs();
        stall = 1;
        fork
            do_write(4'd7, 64'h1000, 8'd255, 3'd3, 2'b01, bid, bresp, ok);
            do_read(4'd4, 64'h3000, 8'd0, 3'd3, 2'b01, ok2);
        join
        stall = 0;
        check("cc_w_done", ok, 1);
        check("cc_r_done", ok2, 1);
        check("cc_aw_n", aw_n, 256);
        check("cc_w_n", w_n, 256);
        check("cc_b_n", b_n, 256);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (aw_log[i] !== 64'h1000 + 64'(i) * 8) errs++;
            if (w_log[i] !== WKEY + 64'(i)) errs++;
        end
        check("cc_beat_errs", errs, 0);
        check("cc_aw_last", aw_log[255], 64'h17F8);
        check("cc_bid", bid, 4'd7);
        check("cc_bresp", bresp, 2'b00);
        check("cc_r_ar", ar_log[0], 64'h3000);
        check("cc_r_d", rd_data[0], 64'h3000 ^ RKEY);
        check("cc_r_last", rd_last[0], 1);
        check("cc_r_id", rd_id[0], 4'd4);

        // reset while in W_BURST after 2 beats
        clear_logs();
        @(negedge clk);
        send_aw(4'd5, 64'h200, 8'd7, 3'd3, 2'b01, ok);
        send_w(WKEY, 1'b0, ok2);
        ok = ok && ok2;
        send_w(WKEY + 64'd1, 1'b0, ok2);
        ok = ok && ok2;
        nb = 0;
        while (b_n < 2 && nb < LIM) begin
            @(negedge clk);
            nb++;
        end
        check("mid_pre_done", ok && b_n == 2, 1);
        rst_ni = 0;
        clear_logs();
        #1;
        check("mid_rst_law", lite_aw_valid_o, 0);
        check("mid_rst_lw", lite_w_valid_o, 0);
        check("mid_rst_lar", lite_ar_valid_o, 0);
        check("mid_rst_b", host_b_valid_o, 0);
        check("mid_rst_r", host_r_valid_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1;
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            #4;
            if (host_b_valid_o) nb++;
        end
        check("mid_no_b", nb, 0);
        check("mid_aw_ready", host_aw_ready_o, 1);
        clear_logs();
        do_write(4'd3, 64'h100, 8'd3, 3'd3, 2'b01, bid, bresp, ok);
        check("post_w_done", ok, 1);
        check("post_aw_n", aw_n, 4);
        check("post_aw3", aw_log[3], 64'h118);
        check("post_bid", bid, 4'd3);
        check("post_bresp", bresp, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
